// File: rtl/lcd_seq_bus_driver_pkg.sv
// rtl/lcd_seq_bus_driver_pkg.sv - shared types and word field positions for the LCD bus driver
package lcd_seq_pkg;

  localparam int LCD_SEQ_WORD_W   = 10;
  localparam int LCD_SEQ_BYTE_W   = 8;
  localparam int LCD_SEQ_BYTE_MSB = 7;
  localparam int LCD_SEQ_RS_BIT   = 8;
  localparam int LCD_SEQ_DLY_BIT  = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DELAY
  } lcd_seq_state_e;

endpackage

// File: rtl/lcd_seq_bus_driver_if.sv
// rtl/lcd_seq_bus_driver_if.sv - word stream handshake plus 8080-style LCD pins
interface lcd_seq_bus_driver_if;
  import lcd_seq_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [LCD_SEQ_WORD_W-1:0] in_data;
  logic                      lcd_cs_n;
  logic                      lcd_wr_n;
  logic                      lcd_rd_n;
  logic                      lcd_rs;
  logic [LCD_SEQ_BYTE_W-1:0] lcd_d;
  logic                      busy;

  modport master (
    output in_valid, in_data,
    input  in_ready, lcd_cs_n, lcd_wr_n, lcd_rd_n, lcd_rs, lcd_d, busy
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, lcd_cs_n, lcd_wr_n, lcd_rd_n, lcd_rs, lcd_d, busy
  );

endinterface

// File: rtl/lcd_seq_bus_driver_delay_timer.sv
// rtl/lcd_seq_bus_driver_delay_timer.sv - prescaled tick counter; done marks the last cycle of N*DELAY_UNIT
module lcd_seq_delay_timer #(
  parameter int DELAY_UNIT = 50
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] n,
  output logic       done
);

  localparam logic [15:0] PRESC_TOP = 16'(DELAY_UNIT - 1);

  logic [15:0] presc;
  logic [7:0]  ticks;

  // The final tick wraps the prescaler and empties the tick counter, leaving the timer idle.
  assign done = (ticks == 8'd1) && (presc == PRESC_TOP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= 16'd0;
      ticks <= 8'd0;
    end else if (load) begin
      presc <= 16'd0;
      ticks <= n;
    end else if (ticks != 8'd0) begin
      if (presc == PRESC_TOP) begin
        presc <= 16'd0;
        ticks <= ticks - 8'd1;
      end else begin
        presc <= presc + 16'd1;
      end
    end
  end

endmodule

// File: rtl/lcd_seq_bus_driver.sv
// rtl/lcd_seq_bus_driver.sv - pops command/data/delay words and drives 8080 write cycles on the LCD pins
// Optional LCD_SEQ_BACK_TO_BACK_EN: accept the next word in the final HOLD cycle.
module lcd_seq_bus_driver
  import lcd_seq_pkg::*;
#(
  parameter int SETUP_CYCLES = 2,
  parameter int PULSE_CYCLES = 3,
  parameter int HOLD_CYCLES  = 2,
  parameter int DELAY_UNIT   = 50
) (
  input logic                 clk,
  input logic                 reset_n,
  lcd_seq_bus_driver_if.slave bus
);

  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] PULSE_LD = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYCLES - 1);

  lcd_seq_state_e            state;
  logic [3:0]                phase;
  logic                      armed;
  logic                      cs_n;
  logic                      wr_n;
  logic                      rs;
  logic [LCD_SEQ_BYTE_W-1:0] d;

  logic                      accept;
  logic                      hold_last;
  logic                      is_delay;
  logic [LCD_SEQ_BYTE_W-1:0] n_field;
  logic                      timer_done;

  assign is_delay  = bus.in_data[LCD_SEQ_DLY_BIT];
  assign n_field   = bus.in_data[LCD_SEQ_BYTE_MSB:0];
  assign hold_last = (state == ST_HOLD) && (phase == 4'd0);

`ifdef LCD_SEQ_BACK_TO_BACK_EN
  assign bus.in_ready = armed && ((state == ST_IDLE) || hold_last);
`else
  assign bus.in_ready = armed && (state == ST_IDLE);
`endif

  assign accept   = bus.in_ready && bus.in_valid;
  assign bus.busy = (state != ST_IDLE);

  assign bus.lcd_cs_n = cs_n;
  assign bus.lcd_wr_n = wr_n;
  assign bus.lcd_rd_n = 1'b1;
  assign bus.lcd_rs   = rs;
  assign bus.lcd_d    = d;

  lcd_seq_delay_timer #(
    .DELAY_UNIT (DELAY_UNIT)
  ) u_delay_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (accept && is_delay),
    .n       (n_field),
    .done    (timer_done)
  );

  // Accept is only possible in IDLE or the final HOLD cycle, so it takes priority over phase sequencing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      phase <= 4'd0;
      armed <= 1'b0;
      cs_n  <= 1'b1;
      wr_n  <= 1'b1;
      rs    <= 1'b0;
      d     <= '0;
    end else begin
      armed <= 1'b1;
      if (accept) begin
        if (!is_delay) begin
          d     <= n_field;
          rs    <= bus.in_data[LCD_SEQ_RS_BIT];
          cs_n  <= 1'b0;
          phase <= SETUP_LD;
          state <= ST_SETUP;
        end else begin
          cs_n  <= 1'b1;
          state <= (n_field == '0) ? ST_IDLE : ST_DELAY;
        end
      end else begin
        case (state)
          ST_SETUP: begin
            if (phase == 4'd0) begin
              wr_n  <= 1'b0;
              phase <= PULSE_LD;
              state <= ST_STROBE;
            end else begin
              phase <= phase - 4'd1;
            end
          end
          ST_STROBE: begin
            if (phase == 4'd0) begin
              wr_n  <= 1'b1;
              phase <= HOLD_LD;
              state <= ST_HOLD;
            end else begin
              phase <= phase - 4'd1;
            end
          end
          ST_HOLD: begin
            if (phase == 4'd0) begin
              cs_n  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              phase <= phase - 4'd1;
            end
          end
          ST_DELAY: begin
            if (timer_done) begin
              state <= ST_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
